// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_add_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/FourBitFullAdder.sv
// Purely combinational 4-bit full adder shared by the serial sequencer.
module FourBitFullAdder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single 4-bit adder,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int NIB  = WIDTH / NIBBLE_W;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;

  logic [NIBBLE_W-1:0] adderA;
  logic [NIBBLE_W-1:0] adderB;
  logic [NIBBLE_W-1:0] adderSum;
  logic                adderCout;

  assign adderA = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign adderB = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  FourBitFullAdder u_adder (
    .a_i   (adderA),
    .b_i   (adderB),
    .cin_i (carry_q),
    .sum_o (adderSum),
    .cout_o(adderCout)
  );

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q == S_RUN) || (state_q == S_DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;

  // The unused encoding falls back to IDLE so a corrupted state self-recovers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            carry_q <= cin_i;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[NIBBLE_W*idx_q +: NIBBLE_W] <= adderSum;
          carry_q <= adderCout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= adderCout;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized self-checking bench for nibble_serial_add_ctrl (WIDTH=16) against plain a+b+cin arithmetic.
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int checkCount = 0;
  int errorCount = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .a_i        (a),
    .b_i        (b),
    .cin_i      (cin),
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .sum_o      (sum),
    .cout_o     (cout),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One full operation: handshake, wait for result, optional backpressure, then drain.
  task automatic applyStimulus(input logic [WIDTH-1:0] aV, input logic [WIDTH-1:0] bV,
                               input logic cinV, input int stall, input bit holdValid);
    logic [WIDTH:0] expVal;
    int guard;
    int edges;
    expVal = {1'b0, aV} + {1'b0, bV} + {{WIDTH{1'b0}}, cinV};
    guard = 0;
    while (!inReady && guard < 50) begin
      tick();
      guard++;
    end
    checkOutput("in_ready_before_op", {31'b0, inReady}, 32'd1);
    outReady = (stall == 0);
    a = aV;
    b = bV;
    cin = cinV;
    inValid = 1'b1;
    tick();
    edges = 1;
    if (!holdValid) inValid = 1'b0;
    checkOutput("busy_in_run", {31'b0, busy}, 32'd1);
    while (!outValid && edges < 20) begin
      if (holdValid) begin
        checkOutput("in_ready_in_run", {31'b0, inReady}, 32'd0);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
      end
      tick();
      edges++;
    end
    checkOutput("latency", edges, NIB + 1);
    checkOutput("sum", {16'b0, sum}, {16'b0, expVal[WIDTH-1:0]});
    checkOutput("cout", {31'b0, cout}, {31'b0, expVal[WIDTH]});
    checkOutput("in_ready_in_done", {31'b0, inReady}, 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      checkOutput("stall_valid", {31'b0, outValid}, 32'd1);
      checkOutput("stall_sum", {16'b0, sum}, {16'b0, expVal[WIDTH-1:0]});
      checkOutput("stall_cout", {31'b0, cout}, {31'b0, expVal[WIDTH]});
      checkOutput("stall_in_ready", {31'b0, inReady}, 32'd0);
    end
    outReady = 1'b1;
    tick();
    checkOutput("valid_after_drain", {31'b0, outValid}, 32'd0);
    checkOutput("in_ready_after_drain", {31'b0, inReady}, 32'd1);
    checkOutput("busy_after_drain", {31'b0, busy}, 32'd0);
    inValid = 1'b0;
  endtask

  initial begin
    int stall;
    rst = 1'b1;
    inValid = 1'b0;
    outReady = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("reset_out_valid", {31'b0, outValid}, 32'd0);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_sum", {16'b0, sum}, 32'd0);
    checkOutput("reset_cout", {31'b0, cout}, 32'd0);

    applyStimulus(16'h1234, 16'h1111, 1'b0, 0, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    applyStimulus(16'h8421, 16'h7BDE, 1'b1, 6, 1'b0);
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b1);
    applyStimulus(16'h1357, 16'h2468, 1'b0, 0, 1'b0);

    // Abort an operation after two nibbles; cout is nonzero from the previous op.
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    a = 16'hABCD;
    b = 16'h1234;
    cin = 1'b1;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrun_rst_valid", {31'b0, outValid}, 32'd0);
    checkOutput("midrun_rst_sum", {16'b0, sum}, 32'd0);
    checkOutput("midrun_rst_cout", {31'b0, cout}, 32'd0);
    checkOutput("midrun_rst_in_ready", {31'b0, inReady}, 32'd1);
    checkOutput("midrun_rst_busy", {31'b0, busy}, 32'd0);
    applyStimulus(16'h00F0, 16'h0010, 1'b0, 0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), stall, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
